// File: rtl/core_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : core_ctrl_if
// Description : Execute-stage/bus inputs and PC/pipeline-control outputs
//               of the core control unit, bundled for connection.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface core_ctrl_if;
  logic        jump_flag_in;
  logic [31:0] jump_addr_in;
  logic        hold_flag_in;
  logic        bus_hold_in;
  logic [31:0] pc_out;
  logic        stall_out;
  logic        flush_out;
  logic        misalign_out;
  logic [1:0]  state_out;
  logic [31:0] stall_cnt_out;

  // Stimulus side: drives execute/bus requests, observes control outputs.
  modport master (
    output jump_flag_in, jump_addr_in, hold_flag_in, bus_hold_in,
    input  pc_out, stall_out, flush_out, misalign_out, state_out, stall_cnt_out
  );

  // Control unit side.
  modport slave (
    input  jump_flag_in, jump_addr_in, hold_flag_in, bus_hold_in,
    output pc_out, stall_out, flush_out, misalign_out, state_out, stall_cnt_out
  );
endinterface

`default_nettype wire

// File: rtl/core_ctrl.sv
//------------------------------------------------------------------------------
// Module      : core_ctrl
// Description : Pipeline control and PC generation. Owns the program
//               counter, drives stall/flush of IF/ID and ID/EX, parks a jump
//               target while the bus is busy and counts stall cycles.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module core_ctrl #(
  parameter logic [31:0] RST_ADDR     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  core_ctrl_if.slave    ctrl
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_PEND  = 2'd3
  } state_t;

  // Counter value loaded on the accept edge; the accept cycle is already
  // one of the flush cycles, hence the minus one.
  localparam logic [2:0] C_FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
  localparam logic       C_FLUSH_MULTI = (FLUSH_CYCLES > 1);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_flush_cnt, w_flush_cnt_nxt;
  logic [31:0] r_pend_addr, w_pend_addr_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_misalign, w_misalign_nxt;
  logic [31:0] r_stall_cnt;
  logic [31:0] w_tgt;
  logic        w_jump_acc;
  logic        w_stall;
  logic        w_flush;

  // Stall decode; outputs are forced low while reset is held.
  always_comb begin
    w_jump_acc = ctrl.jump_flag_in & ~ctrl.bus_hold_in;
    w_stall    = rst & (ctrl.bus_hold_in
                        | (ctrl.hold_flag_in & ~ctrl.jump_flag_in)
                        | (r_state == ST_PEND));
  end

  // Next-state, next-PC and flush decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_pend_addr_nxt = r_pend_addr;
    w_pc_nxt        = w_stall ? r_pc : r_pc + 32'd4;
    w_misalign_nxt  = 1'b0;
    w_flush         = 1'b0;
    w_tgt           = ctrl.jump_addr_in;

    case (r_state)
      ST_PEND: begin
        w_flush = 1'b1;
        if (!ctrl.bus_hold_in) begin
          // A jump arriving on the release cycle is the newest target.
          w_tgt           = ctrl.jump_flag_in ? ctrl.jump_addr_in : r_pend_addr;
          w_pc_nxt        = {w_tgt[31:2], 2'b00};
          w_misalign_nxt  = |w_tgt[1:0];
          w_flush_cnt_nxt = C_FLUSH_LOAD;
          w_state_nxt     = C_FLUSH_MULTI ? ST_FLUSH : ST_RUN;
        end else if (ctrl.jump_flag_in) begin
          w_pend_addr_nxt = ctrl.jump_addr_in;
        end
      end
      default: begin
        if (w_jump_acc) begin
          // Accepted jump wins over any execute hold; also restarts FLUSH.
          w_flush         = 1'b1;
          w_pc_nxt        = {ctrl.jump_addr_in[31:2], 2'b00};
          w_misalign_nxt  = |ctrl.jump_addr_in[1:0];
          w_flush_cnt_nxt = C_FLUSH_LOAD;
          w_state_nxt     = C_FLUSH_MULTI ? ST_FLUSH : ST_RUN;
        end else if (ctrl.jump_flag_in) begin
          // Bus busy: park the target until the front end can move.
          w_flush         = 1'b1;
          w_pend_addr_nxt = ctrl.jump_addr_in;
          w_state_nxt     = ST_PEND;
        end else if (r_state == ST_FLUSH) begin
          w_flush = 1'b1;
          if (r_flush_cnt <= 3'd1) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 3'd1;
          end
        end else begin
          w_state_nxt = w_stall ? ST_HOLD : ST_RUN;
        end
      end
    endcase
  end

  // Control state, PC and pending-target registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 3'd0;
      r_pend_addr <= 32'd0;
      r_pc        <= RST_ADDR;
      r_misalign  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_pc        <= w_pc_nxt;
      r_misalign  <= w_misalign_nxt;
    end
  end

  // Saturating stall-cycle counter for performance debug.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign ctrl.pc_out        = r_pc;
  assign ctrl.stall_out     = w_stall;
  assign ctrl.flush_out     = rst & w_flush;
  assign ctrl.misalign_out  = r_misalign;
  assign ctrl.state_out     = r_state;
  assign ctrl.stall_cnt_out = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_core_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_core_ctrl
// Description : Directed self-checking bench for core_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_core_ctrl;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  core_ctrl_if u_if ();

  core_ctrl #(
    .RST_ADDR     (32'h0000_0000),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic j, input logic [31:0] a, input logic h, input logic b);
    u_if.jump_flag_in = j;
    u_if.jump_addr_in = a;
    u_if.hold_flag_in = h;
    u_if.bus_hold_in  = b;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset state, including stall gating while reset is held.
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    #12;
    chk("rst_stall_gated", u_if.stall_out, 32'd0);
    u_if.bus_hold_in = 1'b0;
    #1;
    chk("rst_pc", u_if.pc_out, 32'h0);
    chk("rst_state", u_if.state_out, 32'd0);
    chk("rst_flush", u_if.flush_out, 32'd0);
    chk("rst_misalign", u_if.misalign_out, 32'd0);
    chk("rst_cnt", u_if.stall_cnt_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Free-running fetch.
    tick(); chk("run_pc4", u_if.pc_out, 32'h4);
    tick(); chk("run_pc8", u_if.pc_out, 32'h8);
    tick(); chk("run_pc12", u_if.pc_out, 32'hC);
    chk("run_cnt", u_if.stall_cnt_out, 32'd0);
    chk("run_stall", u_if.stall_out, 32'd0);
    tick(); chk("run_pc16", u_if.pc_out, 32'h10);

    // Aligned jump at pc=0x10.
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    #1;
    chk("jmp_flush_acc", u_if.flush_out, 32'd1);
    chk("jmp_stall_acc", u_if.stall_out, 32'd0);
    tick();
    chk("jmp_pc", u_if.pc_out, 32'h100);
    chk("jmp_state_flush", u_if.state_out, 32'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("jmp_flush_2nd", u_if.flush_out, 32'd1);
    tick();
    chk("jmp_pc_next", u_if.pc_out, 32'h104);
    chk("jmp_state_run", u_if.state_out, 32'd0);
    chk("jmp_flush_done", u_if.flush_out, 32'd0);

    // Execute hold for three cycles at pc=0x20.
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    chk("hold_start_pc", u_if.pc_out, 32'h20);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    #1;
    chk("hold_stall", u_if.stall_out, 32'd1);
    tick(); chk("hold_pc1", u_if.pc_out, 32'h20);
    chk("hold_state", u_if.state_out, 32'd2);
    tick(); chk("hold_pc2", u_if.pc_out, 32'h20);
    tick(); chk("hold_pc3", u_if.pc_out, 32'h20);
    chk("hold_cnt", u_if.stall_cnt_out, 32'd3);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("hold_release_stall", u_if.stall_out, 32'd0);
    tick();
    chk("hold_release_pc", u_if.pc_out, 32'h24);
    chk("hold_release_state", u_if.state_out, 32'd0);

    // Jump while the bus is busy: parked in PEND for four cycles.
    do_reset();
    tick(); tick();
    chk("pend_start_pc", u_if.pc_out, 32'h8);
    drive(1'b1, 32'h200, 1'b0, 1'b1);
    #1;
    chk("pend_req_stall", u_if.stall_out, 32'd1);
    chk("pend_req_flush", u_if.flush_out, 32'd1);
    tick();
    chk("pend_state", u_if.state_out, 32'd3);
    chk("pend_pc1", u_if.pc_out, 32'h8);
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    tick(); tick(); tick();
    chk("pend_pc4", u_if.pc_out, 32'h8);
    chk("pend_cnt", u_if.stall_cnt_out, 32'd4);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("pend_rel_stall", u_if.stall_out, 32'd1);
    chk("pend_rel_flush", u_if.flush_out, 32'd1);
    tick();
    chk("pend_load_pc", u_if.pc_out, 32'h200);
    chk("pend_load_state", u_if.state_out, 32'd1);
    chk("pend_load_cnt", u_if.stall_cnt_out, 32'd5);
    chk("pend_load_misalign", u_if.misalign_out, 32'd0);
    tick();
    chk("pend_after_pc", u_if.pc_out, 32'h204);
    chk("pend_after_state", u_if.state_out, 32'd0);

    // Misaligned target, and jump beats execute hold in the same cycle.
    drive(1'b1, 32'h203, 1'b1, 1'b0);
    #1;
    chk("jmp_vs_hold_stall", u_if.stall_out, 32'd0);
    tick();
    chk("mis_pc", u_if.pc_out, 32'h200);
    chk("mis_pulse", u_if.misalign_out, 32'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("mis_clear", u_if.misalign_out, 32'd0);
    chk("mis_pc_next", u_if.pc_out, 32'h204);

    // Jump restarting an active flush window.
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    tick();
    chk("restart_pc", u_if.pc_out, 32'h80);
    chk("restart_state", u_if.state_out, 32'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("restart_exit_pc", u_if.pc_out, 32'h84);
    chk("restart_exit_state", u_if.state_out, 32'd0);

    // PC wrap at the top of the address space.
    drive(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("wrap_top", u_if.pc_out, 32'hFFFF_FFFC);
    tick();
    chk("wrap_zero", u_if.pc_out, 32'h0);

    // Reset in the middle of PEND discards the parked target.
    do_reset();
    tick();
    drive(1'b1, 32'h300, 1'b0, 1'b1);
    tick();
    chk("rpend_state", u_if.state_out, 32'd3);
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    chk("rpend_pc", u_if.pc_out, 32'h0);
    chk("rpend_state_run", u_if.state_out, 32'd0);
    chk("rpend_cnt", u_if.stall_cnt_out, 32'd0);
    chk("rpend_stall", u_if.stall_out, 32'd0);
    u_if.bus_hold_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rpend_after_pc", u_if.pc_out, 32'h4);
    chk("rpend_after_state", u_if.state_out, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
